sram_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer for the shared 48-bit SRAM port. It sits between the CPU data port (r_*) and the video-memory writer port (v_*) on one side and the single SRAM controller strobe/ack interface (m_*) on the other. It replaces the current "CPU strobe always wins" steering with one latched, fully handshaked transaction at a time. It returns data and ack only to the owning requester, and aborts any transaction the controller never acknowledges.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arb_pick.sv | 37 +++
 rtl/sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states and owner encodings.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_R    = 2'd1;
  localparam logic [1:0] OWN_V    = 2'd2;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection between CPU and video strobes.
// SRAM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic r_stb,
  input  logic v_stb,
  input  logic last_grant,   // 1: video was granted last
  output logic grant_r,
  output logic grant_v
);

`ifdef SRAM_ARB_RR_EN
  // Tie goes to whichever requester was not granted last.
  always_comb begin
    grant_r = 1'b0;
    grant_v = 1'b0;
    if (r_stb && v_stb) begin
      grant_r = last_grant;
      grant_v = ~last_grant;
    end else begin
      grant_r = r_stb;
      grant_v = v_stb;
    end
  end
`else
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;

  // Fixed priority: CPU beats video.
  always_comb begin
    grant_r = r_stb;
    grant_v = v_stb & ~r_stb;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: one latched, fully handshaked transaction at a time.
// Tie policy set by SRAM_ARB_RR_EN (round-robin) or fixed CPU priority when undefined.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 48,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              r_stb,
  input  logic              r_we,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_din,
  output logic [DATA_W-1:0] r_dout,
  output logic              r_ack,
  output logic              r_err,
  input  logic              v_stb,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [DATA_W-1:0] v_din,
  output logic [DATA_W-1:0] v_dout,
  output logic              v_ack,
  output logic              v_err,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout,
  input  logic              m_ack,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             grant_r_s, grant_v_s, last_grant_s, timeout_s, own_r_s;

  assign timeout_s = (cnt_r == TO_LAST);
  assign own_r_s   = (owner == OWN_R);

`ifdef SRAM_ARB_RR_EN
  logic last_grant_r;

  // Remember who was granted last; reset value makes the CPU win the first tie.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == IDLE && (grant_r_s || grant_v_s)) begin
      last_grant_r <= grant_v_s;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = 1'b1;
`endif

  sram_arb_pick u_pick (
    .r_stb      (r_stb),
    .v_stb      (v_stb),
    .last_grant (last_grant_s),
    .grant_r    (grant_r_s),
    .grant_v    (grant_v_s)
  );

  // State register.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; m_ack is only looked at in BUSY.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_r_s || grant_v_s) state_next_s = BUSY;
        else                        state_next_s = IDLE;
      end
      BUSY: begin
        if (m_ack || timeout_s) state_next_s = DONE;
        else                    state_next_s = BUSY;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Registered datapath and handshake outputs, all moving with the state.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      m_stb  <= 1'b0;
      m_we   <= 1'b0;
      m_addr <= '0;
      m_din  <= '0;
      r_dout <= '0;
      v_dout <= '0;
      r_ack  <= 1'b0;
      v_ack  <= 1'b0;
      r_err  <= 1'b0;
      v_err  <= 1'b0;
      owner  <= OWN_NONE;
      busy   <= 1'b0;
      cnt_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_r_s || grant_v_s) begin
            m_stb  <= 1'b1;
            m_we   <= grant_r_s ? r_we   : v_we;
            m_addr <= grant_r_s ? r_addr : v_addr;
            m_din  <= grant_r_s ? r_din  : v_din;
            owner  <= grant_r_s ? OWN_R  : OWN_V;
            busy   <= 1'b1;
            cnt_r  <= '0;
          end
        end
        BUSY: begin
          if (m_ack) begin
            m_stb <= 1'b0;
            if (own_r_s) r_dout <= m_dout;
            else         v_dout <= m_dout;
            r_ack <= own_r_s;
            v_ack <= ~own_r_s;
          end else if (timeout_s) begin
            // Abort: dout is left as it was, err rides along with ack.
            m_stb <= 1'b0;
            r_ack <= own_r_s;
            v_ack <= ~own_r_s;
            r_err <= own_r_s;
            v_err <= ~own_r_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          r_ack <= 1'b0;
          v_ack <= 1'b0;
          r_err <= 1'b0;
          v_err <= 1'b0;
          owner <= OWN_NONE;
          busy  <= 1'b0;
        end
        default: begin
          m_stb <= 1'b0;
          r_ack <= 1'b0;
          v_ack <= 1'b0;
          r_err <= 1'b0;
          v_err <= 1'b0;
          owner <= OWN_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (TIMEOUT=8).
module tb_sram_arbiter;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic        r_stb = 1'b0, r_we = 1'b0;
  logic [19:0] r_addr = 20'h0;
  logic [47:0] r_din = 48'h0;
  logic [47:0] r_dout;
  logic        r_ack, r_err;
  logic        v_stb = 1'b0, v_we = 1'b0;
  logic [19:0] v_addr = 20'h0;
  logic [47:0] v_din = 48'h0;
  logic [47:0] v_dout;
  logic        v_ack, v_err;
  logic        m_stb, m_we;
  logic [19:0] m_addr;
  logic [47:0] m_din;
  logic [47:0] m_dout = 48'h0;
  logic        m_ack = 1'b0;
  logic [1:0]  owner;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  int          res_cycle, res_busy, res_other, res_hold_bad;
  logic        res_err, res_done;

  always #10 clk_50mhz = ~clk_50mhz;

  sram_arbiter #(.ADDR_W(20), .DATA_W(48), .TIMEOUT(8)) dut (
    .clk_50mhz (clk_50mhz), .rst (rst),
    .r_stb (r_stb), .r_we (r_we), .r_addr (r_addr), .r_din (r_din),
    .r_dout (r_dout), .r_ack (r_ack), .r_err (r_err),
    .v_stb (v_stb), .v_we (v_we), .v_addr (v_addr), .v_din (v_din),
    .v_dout (v_dout), .v_ack (v_ack), .v_err (v_err),
    .m_stb (m_stb), .m_we (m_we), .m_addr (m_addr), .m_din (m_din),
    .m_dout (m_dout), .m_ack (m_ack), .owner (owner), .busy (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction from one requester; the controller acks in BUSY cycle wait_cycles+1
  // (never if -1). Cycle 0 is the cycle in which the strobe is first sampled.
  task automatic run_txn(input bit vid, input bit we, input logic [19:0] addr,
                         input logic [47:0] din, input int wait_cycles,
                         input logic [47:0] rsp, input bit linger);
    int cyc;
    logic [1:0] exp_owner;
    exp_owner = vid ? 2'd2 : 2'd1;
    res_busy = 0; res_other = 0; res_hold_bad = 0; res_done = 1'b0;
    res_err = 1'b0; res_cycle = 0;
    @(negedge clk_50mhz);
    if (vid) begin v_stb = 1'b1; v_we = we; v_addr = addr; v_din = din; end
    else     begin r_stb = 1'b1; r_we = we; r_addr = addr; r_din = din; end
    cyc = 0;
    while (!res_done && cyc < 60) begin
      @(negedge clk_50mhz);
      cyc++;
      if (m_stb) begin
        res_busy++;
        if (m_addr !== addr || m_din !== din || m_we !== we || owner !== exp_owner || busy !== 1'b1)
          res_hold_bad++;
        m_ack = (res_busy == wait_cycles + 1);
        if (m_ack) m_dout = rsp;
      end else begin
        m_ack = linger & m_ack;
      end
      if (vid ? r_ack : v_ack) res_other++;
      if (vid ? v_ack : r_ack) begin
        res_done = 1'b1;
        res_cycle = cyc;
        res_err = vid ? v_err : r_err;
        r_stb = 1'b0;
        v_stb = 1'b0;
      end
    end
    r_stb = 1'b0;
    v_stb = 1'b0;
    check_eq("txn_completed", {63'd0, res_done}, 64'd1);
  endtask

  initial begin
    logic [3:0] seq;
    logic [3:0] exp_seq;
    int n_acks, cyc, last_ack_cyc, stray;

    repeat (2) @(negedge clk_50mhz);
    check_eq("rst_m_stb", {63'd0, m_stb}, 64'd0);
    check_eq("rst_owner", {62'd0, owner}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_acks", {60'd0, r_ack, v_ack, r_err, v_err}, 64'd0);
    check_eq("rst_m_addr", {44'd0, m_addr}, 64'd0);
    check_eq("rst_r_dout", {16'd0, r_dout}, 64'd0);
    check_eq("rst_v_dout", {16'd0, v_dout}, 64'd0);
    rst = 1'b0;

    // CPU read, three wait cycles then ack: ack in cycle 5.
    run_txn(1'b0, 1'b0, 20'h00010, 48'h0, 3, 48'h0000_1234_5678, 1'b0);
    check_eq("rd_r_dout", {16'd0, r_dout}, 64'h0000_1234_5678);
    check_eq("rd_latency", res_cycle, 64'd5);
    check_eq("rd_err", {63'd0, res_err}, 64'd0);
    check_eq("rd_v_ack_quiet", res_other, 64'd0);
    check_eq("rd_hold", res_hold_bad, 64'd0);
    check_eq("rd_v_dout", {16'd0, v_dout}, 64'd0);

    // Video write; latched m_* must stay stable through BUSY.
    run_txn(1'b1, 1'b1, 20'h80005, 48'hABCD_0000_0000, 1, 48'h0000_0000_0BAD, 1'b0);
    check_eq("wr_hold", res_hold_bad, 64'd0);
    check_eq("wr_busy_cycles", res_busy, 64'd2);
    check_eq("wr_latency", res_cycle, 64'd3);
    check_eq("wr_r_ack_quiet", res_other, 64'd0);
    check_eq("wr_v_dout", {16'd0, v_dout}, 64'h0000_0000_0BAD);
    check_eq("wr_r_dout_kept", {16'd0, r_dout}, 64'h0000_1234_5678);
    check_eq("wr_m_we", {63'd0, m_we}, 64'd1);
    check_eq("wr_m_addr", {44'd0, m_addr}, 64'h80005);
    check_eq("wr_m_din", {16'd0, m_din}, 64'hABCD_0000_0000);
    @(negedge clk_50mhz);
    check_eq("wr_v_ack_single", {63'd0, v_ack}, 64'd0);

    // Controller never acks: abort after 8 BUSY cycles, ack+err in cycle 9.
    run_txn(1'b0, 1'b0, 20'h00123, 48'h0, -1, 48'hFFFF_FFFF_FFFF, 1'b0);
    check_eq("to_busy_cycles", res_busy, 64'd8);
    check_eq("to_latency", res_cycle, 64'd9);
    check_eq("to_err", {63'd0, res_err}, 64'd1);
    check_eq("to_r_dout_kept", {16'd0, r_dout}, 64'h0000_1234_5678);
    check_eq("to_v_quiet", res_other, 64'd0);
    run_txn(1'b0, 1'b1, 20'h00200, 48'h5555_AAAA_5555, 0, 48'h0000_0000_7777, 1'b0);
    check_eq("after_to_latency", res_cycle, 64'd2);
    check_eq("after_to_err", {63'd0, res_err}, 64'd0);
    check_eq("after_to_r_dout", {16'd0, r_dout}, 64'h0000_0000_7777);

    // Both strobes held for four transactions, fresh from reset.
    @(negedge clk_50mhz); rst = 1'b1;
    @(negedge clk_50mhz); rst = 1'b0;
    r_we = 1'b0; r_addr = 20'h00001; r_din = 48'h0;
    v_we = 1'b1; v_addr = 20'h00002; v_din = 48'h0000_0000_0022;
    r_stb = 1'b1; v_stb = 1'b1;
    seq = 4'b0; n_acks = 0; cyc = 0; last_ack_cyc = 0; stray = 0;
    while (n_acks < 4 && cyc < 60) begin
      @(negedge clk_50mhz);
      cyc++;
      m_ack = m_stb;
      m_dout = 48'h0000_0000_0042;
      if (r_ack && v_ack) stray++;
      if (r_ack || v_ack) begin
        seq[n_acks] = v_ack;
        n_acks++;
        last_ack_cyc = cyc;
      end
    end
    r_stb = 1'b0; v_stb = 1'b0; m_ack = 1'b0;
`ifdef SRAM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    check_eq("tie_count", n_acks, 64'd4);
    check_eq("tie_grants", {60'd0, seq}, {60'd0, exp_seq});
    check_eq("tie_last_ack_cycle", last_ack_cyc, 64'd11);
    check_eq("tie_exclusive", stray, 64'd0);

    // Reset during BUSY drops the transaction with no ack.
    @(negedge clk_50mhz);
    r_stb = 1'b1; r_we = 1'b0; r_addr = 20'h00300;
    repeat (2) @(negedge clk_50mhz);
    check_eq("mid_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_m_stb", {63'd0, m_stb}, 64'd0);
    check_eq("mid_owner", {62'd0, owner}, 64'd0);
    check_eq("mid_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_r_dout", {16'd0, r_dout}, 64'd0);
    r_stb = 1'b0;
    @(negedge clk_50mhz); rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk_50mhz);
      if (r_ack || v_ack || m_stb) stray++;
    end
    check_eq("mid_no_ack", stray, 64'd0);
    run_txn(1'b1, 1'b0, 20'h00400, 48'h0, 2, 48'h0000_00C0_FFEE, 1'b0);
    check_eq("mid_after_latency", res_cycle, 64'd4);
    check_eq("mid_after_v_dout", {16'd0, v_dout}, 64'h0000_00C0_FFEE);

    // m_ack while IDLE: nothing happens.
    @(negedge clk_50mhz); m_ack = 1'b1; m_dout = 48'hDEAD_DEAD_DEAD;
    stray = 0;
    repeat (2) begin
      @(negedge clk_50mhz);
      if (busy || m_stb || owner != 2'd0 || r_ack || v_ack) stray++;
    end
    m_ack = 1'b0;
    check_eq("idle_ack_ignored", stray, 64'd0);
    check_eq("idle_ack_r_dout", {16'd0, r_dout}, 64'd0);

    // m_ack held through DONE and the following IDLE: single ack only.
    run_txn(1'b0, 1'b0, 20'h00500, 48'h0, 0, 48'h0000_0000_0055, 1'b1);
    stray = 0;
    repeat (2) begin
      @(negedge clk_50mhz);
      if (busy || m_stb || r_ack || v_ack) stray++;
    end
    m_ack = 1'b0;
    check_eq("done_ack_ignored", stray, 64'd0);
    check_eq("done_ack_r_dout", {16'd0, r_dout}, 64'h0000_0000_0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
